// File: rtl/scr_pkg.sv
// Shared types and helpers for the scrambler output buffer.
// Word and drop-counter widths plus the per-byte parity helper.
package scr_pkg;

    localparam int WORD_W = 32;
    localparam int DROP_W = 8;

    typedef logic [WORD_W-1:0] scr_word_t;

    // Bit i is the XOR of byte i, so each byte plus its parity bit has even weight.
    function automatic logic [3:0] byte_par4(input scr_word_t d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/scr_out_buffer_if.sv
// Word stream between the scrambler side and the stop-based downstream side.
// SCR_OUT_PARITY_EN adds a per-byte parity lane travelling with the output word.
interface scr_out_buffer_if;
    import scr_pkg::*;

    logic      pushin;
    scr_word_t datain;
    logic      stopin;
    logic      pushout;
    scr_word_t dataout;
    logic      lastout;
`ifdef SCR_OUT_PARITY_EN
    logic [3:0] parout;

    modport master (
        output pushin, datain, stopin,
        input  pushout, dataout, lastout, parout
    );

    modport slave (
        input  pushin, datain, stopin,
        output pushout, dataout, lastout, parout
    );
`else
    modport master (
        output pushin, datain, stopin,
        input  pushout, dataout, lastout
    );

    modport slave (
        input  pushin, datain, stopin,
        output pushout, dataout, lastout
    );
`endif

endinterface

// File: rtl/scr_fifo_ram.sv
// FIFO storage: synchronous write port, combinational read port, no reset on the array.
// Read data follows raddr in the same cycle; no flow control lives here.
module scr_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/scr_out_buffer.sv
// Burst-absorbing FWFT buffer behind the scrambler with frame tagging and drop accounting.
// Latency 1 cycle push-to-pushout; stopin stalls the head, pushes into a full FIFO are dropped (SCR_OUT_PARITY_EN adds parout).
module scr_out_buffer
    import scr_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int FRAME_WORDS = 8,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_ovf,
    scr_out_buffer_if.slave   bus,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

`ifdef SCR_OUT_PARITY_EN
    localparam int STORE_W = WORD_W + 4;
`else
    localparam int STORE_W = WORD_W;
`endif

    localparam logic [7:0] FRAME_LAST = 8'(FRAME_WORDS - 1);

    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [7:0]         frame_cnt;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               drop;
    logic [STORE_W-1:0] wr_word;
    logic [STORE_W-1:0] rd_word;

    // Equal low bits with differing wrap bits means the writer is a full lap ahead.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign pop  = bus.pushout & ~bus.stopin;
    assign push = bus.pushin & (~full | pop);
    assign drop = bus.pushin & full & ~pop;

`ifdef SCR_OUT_PARITY_EN
    assign wr_word    = {byte_par4(bus.datain), bus.datain};
    assign bus.parout = empty ? 4'd0 : rd_word[STORE_W-1:WORD_W];
`else
    assign wr_word = bus.datain;
`endif

    scr_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (STORE_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_word),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
        end else if (push && !pop) begin
            level <= level + (AW+1)'(1);
        end else if (pop && !push) begin
            level <= level - (AW+1)'(1);
        end
    end

    // Frame position advances only on words actually taken downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (pop) begin
            if (bus.lastout) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= DROP_W'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    assign bus.pushout = ~empty;
    assign bus.dataout = empty ? '0 : rd_word[WORD_W-1:0];
    assign bus.lastout = ~empty & (frame_cnt == FRAME_LAST);

endmodule

// File: tb/tb_scr_out_buffer.sv
// Directed bench for scr_out_buffer: stimulus queues expected words, a negedge monitor checks every pop.
module tb_scr_out_buffer;
    import scr_pkg::*;

    localparam int DEPTH = 16;
    localparam int FW    = 8;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_ovf;
    logic [4:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   acc_idx  = 0;
    int   out_cnt  = 0;
    int   last_cnt = 0;

    scr_out_buffer_if bus ();

    scr_out_buffer #(
        .DEPTH       (DEPTH),
        .FRAME_WORDS (FW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr_ovf  (clr_ovf),
        .bus      (bus),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a word leaves whenever pushout is high and stopin low at mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.pushout === 1'b1 && bus.stopin === 1'b0) begin
            out_cnt++;
            if (bus.lastout === 1'b1) last_cnt++;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %0h, expected no output", bus.dataout);
            end else begin
                mon_e = q.pop_front();
                chk("dataout", bus.dataout, mon_e.d);
                chk("lastout", 32'(bus.lastout), 32'(mon_e.last));
`ifdef SCR_OUT_PARITY_EN
                chk("parout", 32'(bus.parout),
                    32'({^mon_e.d[31:24], ^mon_e.d[23:16], ^mon_e.d[15:8], ^mon_e.d[7:0]}));
`endif
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [31:0] d, input bit acc);
        bus.pushin = 1'b1;
        bus.datain = d;
        if (acc) begin
            q.push_back('{d: d, last: ((acc_idx % FW) == FW - 1)});
            acc_idx++;
        end
        @(posedge clk);
        #1;
        bus.pushin = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0 && bus.pushout === 1'b0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic do_reset(input string name);
        #2;
        rst = 1'b0;
        #1;
        chk({name, "_pushout"},  32'(bus.pushout), 32'd0);
        chk({name, "_level"},    32'(level),       32'd0);
        chk({name, "_overflow"}, 32'(overflow),    32'd0);
        chk({name, "_lastout"},  32'(bus.lastout), 32'd0);
        q.delete();
        acc_idx  = 0;
        out_cnt  = 0;
        last_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        clr_ovf    = 1'b0;
        bus.pushin = 1'b0;
        bus.datain = '0;
        bus.stopin = 1'b0;

        #12;
        chk("rst_pushout",  32'(bus.pushout), 32'd0);
        chk("rst_lastout",  32'(bus.lastout), 32'd0);
        chk("rst_dataout",  bus.dataout,      32'd0);
        chk("rst_level",    32'(level),       32'd0);
        chk("rst_overflow", 32'(overflow),    32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Three words through an idle FIFO: one-cycle latency, level never above 1.
        drive(32'hA5A5_0001, 1'b1);
        chk("t1_pushout_rise", 32'(bus.pushout), 32'd1);
        chk("t1_level_a", 32'(level), 32'd1);
        drive(32'hA5A5_0002, 1'b1);
        chk("t1_level_b", 32'(level), 32'd1);
        drive(32'hA5A5_0003, 1'b1);
        chk("t1_level_c", 32'(level), 32'd1);
        wait_drain("t1_drain");
        chk("t1_level_end", 32'(level), 32'd0);
        chk("t1_no_last", 32'(last_cnt), 32'd0);

        // Fill under stall, one drop, then release.
        bus.stopin = 1'b1;
        for (int i = 0; i < DEPTH; i++) drive(32'hB000_0000 + 32'(i), 1'b1);
        chk("t2_level_full", 32'(level), 32'd16);
        drive(32'hBADB_AD17, 1'b0);
        chk("t2_level_after_drop", 32'(level), 32'd16);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_drop_cnt", 32'(drop_cnt), 32'd1);
        bus.stopin = 1'b0;
        wait_drain("t2_drain");
        chk("t2_level_end", 32'(level), 32'd0);

        // Clear, refill, then push and pop together while full.
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        chk("t3_clr_overflow", 32'(overflow), 32'd0);
        chk("t3_clr_drop_cnt", 32'(drop_cnt), 32'd0);
        bus.stopin = 1'b1;
        for (int i = 0; i < DEPTH; i++) drive(32'hC000_0000 + 32'(i), 1'b1);
        bus.stopin = 1'b0;
        drive(32'hC0DE_0017, 1'b1);
        chk("t3_level_stays", 32'(level), 32'd16);
        chk("t3_no_drop", 32'(drop_cnt), 32'd0);
        chk("t3_no_overflow", 32'(overflow), 32'd0);
        wait_drain("t3_drain");

        // 20 back-to-back words: lastout on words 8 and 16, frame counter ends at 4.
        do_reset("t4_rst");
        for (int i = 0; i < 20; i++) drive(32'hD000_0000 + 32'(i), 1'b1);
        wait_drain("t4_drain");
        chk("t4_last_cnt", 32'(last_cnt), 32'd2);
        chk("t4_frame_cnt", 32'(dut.frame_cnt), 32'd4);
        chk("t4_out_cnt", 32'(out_cnt), 32'd20);

        // Saturating drop counter and clear-vs-drop priority.
        do_reset("t5_rst");
        bus.stopin = 1'b1;
        for (int i = 0; i < DEPTH; i++) drive(32'hE000_0000 + 32'(i), 1'b1);
        for (int i = 0; i < 300; i++) drive(32'hEEEE_0000 + 32'(i), 1'b0);
        chk("t5_drop_sat", 32'(drop_cnt), 32'd255);
        chk("t5_overflow", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        drive(32'hEEEE_FFFF, 1'b0);
        clr_ovf = 1'b0;
        chk("t5_clr_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("t5_clr_drop_ovf", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        chk("t5_clr_cnt", 32'(drop_cnt), 32'd0);
        chk("t5_clr_ovf", 32'(overflow), 32'd0);
        bus.stopin = 1'b0;
        wait_drain("t5_drain");

        // Reset mid-burst flushes; only the post-reset word comes out.
        bus.stopin = 1'b1;
        for (int i = 0; i < 5; i++) drive(32'hF000_0000 + 32'(i), 1'b1);
        chk("t6_level_5", 32'(level), 32'd5);
        do_reset("t6_rst");
        bus.stopin = 1'b0;
        drive(32'hDEAD_0001, 1'b1);
        wait_drain("t6_drain");
        chk("t6_out_cnt", 32'(out_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scr_out_buffer.md
Name: scr_out_buffer

Overview:
- Downstream neighbour of the scrambler top. Consumes the scrambled 32-bit word stream (pushout/dataout).
- The scrambler has no backpressure, so this block absorbs bursts in a FIFO and re-emits words with a stop-based handshake.
- Tags frame boundaries on the output and reports dropped words.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- FRAME_WORDS, 8, words per output frame; range 1..256.
- AW, $clog2(DEPTH), pointer index width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- pushin  input  1  scrambled word valid; driven by the scrambler's pushout.
- datain  input  32  scrambled word; driven by the scrambler's dataout.
- stopin  input  1  downstream stall; 1 = do not pop this cycle.
- clr_ovf  input  1  single-cycle pulse; clears overflow and drop_cnt.
- pushout  output  1  output word valid.
- dataout  output  32  output word (FIFO head).
- lastout  output  1  marks the final word of a frame; qualified by pushout.
- level  output  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: at least one word dropped.
- drop_cnt  output  8  count of dropped words; saturates at 255.

Behaviour:
- Reset (rst=0, asynchronous): read and write pointers = 0, level = 0, frame counter = 0, overflow = 0, drop_cnt = 0.
  - Outputs during reset: pushout = 0, lastout = 0, dataout = 0.
- Pointers are AW+1 bits wide. The MSB distinguishes full from empty.
  - empty: pointers equal.
  - full: low AW bits equal and MSBs differ.
  - Pointers wrap modulo 2*DEPTH with no special casing.
- pop = pushout & ~stopin.
- push = pushin & (~full | pop).
  - When full, a push is accepted in the same cycle as a pop.
- Drop condition: pushin & full & ~pop.
  - The word is discarded.
  - overflow is set to 1.
  - drop_cnt increments; it holds at 255 once reached.
- clr_ovf = 1 clears overflow and drop_cnt on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow = 1 and drop_cnt = 1.
- Output is first-word-fall-through:
  - pushout = ~empty (registered from the pointers).
  - dataout = mem[rd_ptr]; dataout = 0 while empty.
- Latency: a word pushed at edge N appears on dataout/pushout after edge N, i.e. in cycle N+1, when the FIFO was empty.
  - There is no combinational path from pushin to pushout.
- While stopin = 1, dataout and lastout hold stable; nothing is lost.
- Simultaneous push and pop at level L: level stays L, including L = 0? No.
  - At L = 0 a pop is impossible (pushout = 0), so the push alone raises level to 1.
- Frame counter (8 bits) counts pops.
  - lastout = pushout & (frame_cnt == FRAME_WORDS-1).
  - On a pop where lastout = 1, frame_cnt returns to 0; otherwise it increments.
  - FRAME_WORDS = 1 means every word is a last word.
- level updates every cycle: +1 push only, -1 pop only, unchanged for both or neither.
- Reset asserted mid-burst flushes the FIFO contents. No partial-frame recovery.

Optional Feature:
- Macro: SCR_OUT_PARITY_EN.
- Defined:
  - Adds output port parout [3:0] = even parity of each byte of dataout (bit i covers dataout[8i+7:8i]).
  - Parity is computed at FIFO write and stored in the FIFO alongside the data (storage width 36).
  - parout = 0 when empty.
- Undefined: the port is absent and storage width is 32.

Decomposition:
- Package scr_pkg:
  - localparam WORD_W = 32.
  - localparam DROP_W = 8.
  - Typedef scr_word_t (logic [WORD_W-1:0]).
  - Parity function byte_par4 for the optional feature.
- One sub-module: scr_fifo_ram.
  - Storage array plus write port and combinational read.
  - Parameterised by DEPTH and width.
  - Pointer, flag and frame logic stay in the parent.

Test Plan:
- Reset then 3 pushes (0xA5A5_0001..0003), stopin = 0 → pushout rises one cycle after the first push; words out in order; level peaks at 1; lastout = 0.
- stopin = 1, 16 pushes → level = 16, full; a 17th push → overflow = 1, drop_cnt = 1, word not stored; release stopin → exactly the 16 original words out, in order.
- Full FIFO, pushin and pop in the same cycle → level stays 16; no drop; the new word emerges after the 16th.
- 20 continuous words, FRAME_WORDS = 8 → lastout on output words 8 and 16; frame_cnt = 4 after word 20.
- 300 drops with stopin held → drop_cnt saturates at 255; clr_ovf together with a drop in the same cycle → overflow = 1, drop_cnt = 1.
- Assert rst low mid-burst at level = 5 → pushout, level and overflow go to 0 immediately (asynchronously); after release, the next push is output alone.
